// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing and test-pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        BARS     = 2'd0,
        CHECKER  = 2'd1,
        GRADIENT = 2'd2,
        SOLID    = 2'd3
    } pattern_mode_e;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33
    };

    // {R,G,B} on/off per bar, left to right
    localparam logic [2:0] BAR_COLOURS [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    localparam int FRAME_CNT_W = 8;

    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        return BAR_COLOURS[idx];
    endfunction

endpackage

// File: rtl/vga_timing_pattern_if.sv
// Video output bundle: syncs, blanking, coordinates, address and colour.
interface vga_timing_pattern_if #(
    parameter int CW     = 4,
    parameter int XW     = 10,
    parameter int YW     = 10,
    parameter int ADDR_W = 19
);
    logic              hClk;
    logic              vClk;
    logic              de;
    logic [XW-1:0]     xCor;
    logic [YW-1:0]     yCor;
    logic [ADDR_W-1:0] addr;
    logic              frameStart;
    logic [CW-1:0]     VGA_R;
    logic [CW-1:0]     VGA_G;
    logic [CW-1:0]     VGA_B;

    modport master (
        output hClk, vClk, de, xCor, yCor, addr, frameStart, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input hClk, vClk, de, xCor, yCor, addr, frameStart, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counters with raw (unregistered) sync, blank
// and frame-boundary decode.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter vga_timing_t TIMING = VGA_640X480,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0,
    parameter int          XW     = 10,
    parameter int          YW     = 10
) (
    input  logic          pixel_clk,
    input  logic          reset_n,
    input  logic          pix_en,
    output logic [XW-1:0] h_cnt,
    output logic [YW-1:0] v_cnt,
    output logic          hs_s,
    output logic          vs_s,
    output logic          de_s,
    output logic          frame_start_s,
    output logic          frame_last_s
);
    localparam int H_ACTIVE = int'(TIMING.h_active);
    localparam int H_SYNC0  = H_ACTIVE + int'(TIMING.h_fp);
    localparam int H_SYNC1  = H_SYNC0 + int'(TIMING.h_sync);
    localparam int H_TOTAL  = H_SYNC1 + int'(TIMING.h_bp);
    localparam int V_ACTIVE = int'(TIMING.v_active);
    localparam int V_SYNC0  = V_ACTIVE + int'(TIMING.v_fp);
    localparam int V_SYNC1  = V_SYNC0 + int'(TIMING.v_sync);
    localparam int V_TOTAL  = V_SYNC1 + int'(TIMING.v_bp);

    logic [XW-1:0] h_cnt_r;
    logic [YW-1:0] v_cnt_r;
    logic [31:0]   h_ext_s;
    logic [31:0]   v_ext_s;
    logic          h_last_s;
    logic          v_last_s;

    // Position counters: hCnt wraps each line, vCnt steps on hCnt wrap
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            h_cnt_r <= {XW{1'b0}};
            v_cnt_r <= {YW{1'b0}};
        end else if (pix_en) begin
            if (h_last_s) begin
                h_cnt_r <= {XW{1'b0}};
                v_cnt_r <= v_last_s ? {YW{1'b0}} : v_cnt_r + YW'(1'b1);
            end else begin
                h_cnt_r <= h_cnt_r + XW'(1'b1);
            end
        end else begin
            h_cnt_r <= h_cnt_r;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Decode of the current position into region flags
    always_comb begin
        h_ext_s       = 32'(h_cnt_r);
        v_ext_s       = 32'(v_cnt_r);
        h_last_s      = (h_ext_s == 32'(H_TOTAL - 1));
        v_last_s      = (v_ext_s == 32'(V_TOTAL - 1));
        hs_s          = ((h_ext_s >= 32'(H_SYNC0)) && (h_ext_s < 32'(H_SYNC1))) ? HS_POL : ~HS_POL;
        vs_s          = ((v_ext_s >= 32'(V_SYNC0)) && (v_ext_s < 32'(V_SYNC1))) ? VS_POL : ~VS_POL;
        de_s          = (h_ext_s < 32'(H_ACTIVE)) && (v_ext_s < 32'(V_ACTIVE));
        frame_start_s = (h_ext_s == 32'd0) && (v_ext_s == 32'd0);
        frame_last_s  = h_last_s && v_last_s;
    end

    assign h_cnt = h_cnt_r;
    assign v_cnt = v_cnt_r;

endmodule

// File: rtl/vga_timing_pattern.sv
// Programmable VGA timing generator with framebuffer address and selectable
// test pattern; every output leaves through one register stage.
module vga_timing_pattern
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 4,
    parameter int ADDR_W   = 19
) (
    input  logic                  pixelClk,
    input  logic                  reset_n,
    input  logic                  pixEn,
    input  logic [1:0]            mode,
    input  logic [3*CW-1:0]       solidRGB,
    vga_timing_pattern_if.master  vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);

    localparam vga_timing_t TIMING = '{
        h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
        v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
    };

    logic [XW-1:0]          h_cnt_s;
    logic [YW-1:0]          v_cnt_s;
    logic                   hs_s;
    logic                   vs_s;
    logic                   de_s;
    logic                   frame_start_s;
    logic                   frame_last_s;

    logic [ADDR_W-1:0]      addr_cnt_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    pattern_mode_e          mode_sh_r;
    logic [3*CW-1:0]        solid_sh_r;
    pattern_mode_e          mode_eff_s;
    logic [3*CW-1:0]        solid_eff_s;

    logic [31:0]            x_ext_s;
    logic [31:0]            x_blk_s;
    logic [31:0]            y_blk_s;
    logic [2:0]             bar_idx_s;
    logic [2:0]             bar_rgb_s;
    logic [CW-1:0]          r_s;
    logic [CW-1:0]          g_s;
    logic [CW-1:0]          b_s;

    logic                   hs_r;
    logic                   vs_r;
    logic                   de_r;
    logic [XW-1:0]          x_cor_r;
    logic [YW-1:0]          y_cor_r;
    logic [ADDR_W-1:0]      addr_r;
    logic                   frame_start_r;
    logic [CW-1:0]          r_r;
    logic [CW-1:0]          g_r;
    logic [CW-1:0]          b_r;

    vga_sync_counter #(
        .TIMING (TIMING),
        .HS_POL (HS_POL),
        .VS_POL (VS_POL),
        .XW     (XW),
        .YW     (YW)
    ) u_sync (
        .pixel_clk     (pixelClk),
        .reset_n       (reset_n),
        .pix_en        (pixEn),
        .h_cnt         (h_cnt_s),
        .v_cnt         (v_cnt_s),
        .hs_s          (hs_s),
        .vs_s          (vs_s),
        .de_s          (de_s),
        .frame_start_s (frame_start_s),
        .frame_last_s  (frame_last_s)
    );

    // Address, frame counter and per-frame mode shadow, tracking counter state
    always_ff @(posedge pixelClk) begin
        if (!reset_n) begin
            addr_cnt_r  <= {ADDR_W{1'b0}};
            frame_cnt_r <= {FRAME_CNT_W{1'b0}};
            mode_sh_r   <= BARS;
            solid_sh_r  <= {(3*CW){1'b0}};
        end else if (pixEn) begin
            // addr points at the pixel the counters currently sit on
            if (frame_last_s) begin
                addr_cnt_r <= {ADDR_W{1'b0}};
            end else if (de_s) begin
                addr_cnt_r <= addr_cnt_r + ADDR_W'(1'b1);
            end else begin
                addr_cnt_r <= addr_cnt_r;
            end
            frame_cnt_r <= frame_last_s ? frame_cnt_r + FRAME_CNT_W'(1'b1) : frame_cnt_r;
            mode_sh_r   <= mode_eff_s;
            solid_sh_r  <= solid_eff_s;
        end else begin
            addr_cnt_r  <= addr_cnt_r;
            frame_cnt_r <= frame_cnt_r;
            mode_sh_r   <= mode_sh_r;
            solid_sh_r  <= solid_sh_r;
        end
    end

    // Pixel (0,0) already uses the settings captured at that boundary
    always_comb begin
        mode_eff_s  = mode_sh_r;
        solid_eff_s = solid_sh_r;
        if (frame_start_s) begin
            mode_eff_s  = pattern_mode_e'(mode);
            solid_eff_s = solidRGB;
        end else begin
            mode_eff_s  = mode_sh_r;
            solid_eff_s = solid_sh_r;
        end
    end

    // Colour-bar index from the integer bar edges k*H_ACTIVE/8
    always_comb begin
        x_ext_s   = 32'(h_cnt_s);
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_ext_s >= 32'((k * H_ACTIVE) / 8)) begin
                bar_idx_s = 3'(k);
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
    end

    // Pattern mux; blanked outside the visible area
    always_comb begin
        x_blk_s   = 32'(h_cnt_s) >> 5;
        y_blk_s   = 32'(v_cnt_s) >> 5;
        bar_rgb_s = bar_colour(bar_idx_s);
        r_s       = {CW{1'b0}};
        g_s       = {CW{1'b0}};
        b_s       = {CW{1'b0}};
        if (de_s) begin
            case (mode_eff_s)
                BARS: begin
                    r_s = {CW{bar_rgb_s[2]}};
                    g_s = {CW{bar_rgb_s[1]}};
                    b_s = {CW{bar_rgb_s[0]}};
                end
                CHECKER: begin
                    r_s = {CW{~(x_blk_s[0] ^ y_blk_s[0])}};
                    g_s = {CW{~(x_blk_s[0] ^ y_blk_s[0])}};
                    b_s = {CW{~(x_blk_s[0] ^ y_blk_s[0])}};
                end
                GRADIENT: begin
                    r_s = CW'(x_blk_s);
                    g_s = CW'(y_blk_s);
                    b_s = CW'(frame_cnt_r);
                end
                SOLID: begin
                    {r_s, g_s, b_s} = solid_eff_s;
                end
                default: begin
                    r_s = {CW{1'b0}};
                    g_s = {CW{1'b0}};
                    b_s = {CW{1'b0}};
                end
            endcase
        end else begin
            r_s = {CW{1'b0}};
            g_s = {CW{1'b0}};
            b_s = {CW{1'b0}};
        end
    end

    // Output stage: all pins move together, one cycle behind the counters
    always_ff @(posedge pixelClk) begin
        if (!reset_n) begin
            hs_r          <= ~HS_POL;
            vs_r          <= ~VS_POL;
            de_r          <= 1'b0;
            x_cor_r       <= {XW{1'b0}};
            y_cor_r       <= {YW{1'b0}};
            addr_r        <= {ADDR_W{1'b0}};
            frame_start_r <= 1'b0;
            r_r           <= {CW{1'b0}};
            g_r           <= {CW{1'b0}};
            b_r           <= {CW{1'b0}};
        end else if (pixEn) begin
            hs_r          <= hs_s;
            vs_r          <= vs_s;
            de_r          <= de_s;
            x_cor_r       <= h_cnt_s;
            y_cor_r       <= v_cnt_s;
            addr_r        <= addr_cnt_r;
            frame_start_r <= frame_start_s;
            r_r           <= r_s;
            g_r           <= g_s;
            b_r           <= b_s;
        end else begin
            hs_r          <= hs_r;
            vs_r          <= vs_r;
            de_r          <= de_r;
            x_cor_r       <= x_cor_r;
            y_cor_r       <= y_cor_r;
            addr_r        <= addr_r;
            frame_start_r <= frame_start_r;
            r_r           <= r_r;
            g_r           <= g_r;
            b_r           <= b_r;
        end
    end

    assign vid.hClk       = hs_r;
    assign vid.vClk       = vs_r;
    assign vid.de         = de_r;
    assign vid.xCor       = x_cor_r;
    assign vid.yCor       = y_cor_r;
    assign vid.addr       = addr_r;
    assign vid.frameStart = frame_start_r;
    assign vid.VGA_R      = r_r;
    assign vid.VGA_G      = g_r;
    assign vid.VGA_B      = b_r;

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Scoreboard bench: a position-based reference model predicts every output
// word, a negedge monitor compares, plus sync-width and frame-period checks.
module tb_vga_timing_pattern;
    localparam int  HA = 70, HFP = 4, HSW = 8, HBP = 6;
    localparam int  VA = 40, VFP = 2, VSW = 3, VBP = 2;
    localparam bit  HS_POL = 1'b1, VS_POL = 1'b0;
    localparam int  CW = 4, ADDR_W = 12;
    localparam int  H_TOTAL = HA + HFP + HSW + HBP;
    localparam int  V_TOTAL = VA + VFP + VSW + VBP;
    localparam int  FRAME = H_TOTAL * V_TOTAL;
    localparam int  XW = 7, YW = 6;

    logic        pixelClk = 1'b0;
    logic        reset_n;
    logic        pixEn;
    logic [1:0]  mode;
    logic [11:0] solidRGB;

    vga_timing_pattern_if #(.CW(CW), .XW(XW), .YW(YW), .ADDR_W(ADDR_W)) vid ();

    vga_timing_pattern #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .ADDR_W(ADDR_W)
    ) dut (
        .pixelClk (pixelClk),
        .reset_n  (reset_n),
        .pixEn    (pixEn),
        .mode     (mode),
        .solidRGB (solidRGB),
        .vid      (vid.master)
    );

    always #5 pixelClk = ~pixelClk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2:0]  bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    int          m_h, m_v, m_frame, m_mode;
    logic [11:0] m_solid;
    logic [40:0] last_exp;
    logic [40:0] exp_q [$];
    bit          en_seen = 1'b0;
    bit          rst_seen = 1'b0;

    function automatic logic [40:0] model_out(input int h, input int v);
        bit         hs, vs, de, fs;
        int         a, k;
        logic [2:0] c;
        logic [3:0] r, g, b;
        hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL : !HS_POL;
        vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL : !VS_POL;
        de = (h < HA) && (v < VA);
        fs = (h == 0) && (v == 0);
        if (v >= VA)     a = VA * HA;
        else if (h < HA) a = v * HA + h;
        else             a = (v + 1) * HA;
        r = 4'h0; g = 4'h0; b = 4'h0;
        if (de) begin
            case (m_mode)
                0: begin
                    k = 0;
                    for (int j = 1; j < 8; j++) if (h >= (j * HA) / 8) k = j;
                    c = bar_tab[k];
                    r = c[2] ? 4'hF : 4'h0;
                    g = c[1] ? 4'hF : 4'h0;
                    b = c[0] ? 4'hF : 4'h0;
                end
                1: begin
                    r = ((((h / 32) % 2) ^ ((v / 32) % 2)) == 0) ? 4'hF : 4'h0;
                    g = r;
                    b = r;
                end
                2: begin
                    r = 4'((h / 32) % 16);
                    g = 4'((v / 32) % 16);
                    b = 4'(m_frame % 16);
                end
                default: {r, g, b} = m_solid;
            endcase
        end
        return {hs, vs, de, fs, 7'(h), 6'(v), 12'(a), r, g, b};
    endfunction

    // Model advance at each active edge; pushes the word expected after it
    always @(posedge pixelClk) begin
        if (!reset_n) begin
            m_h = 0; m_v = 0; m_frame = 0; m_mode = 0; m_solid = 12'h000;
            last_exp = {!HS_POL, !VS_POL, 39'd0};
            en_seen = 1'b0; rst_seen = 1'b1;
        end else if (pixEn) begin
            if (m_h == 0 && m_v == 0) begin
                m_mode  = int'(mode);
                m_solid = solidRGB;
            end
            last_exp = model_out(m_h, m_v);
            m_h++;
            if (m_h == H_TOTAL) begin
                m_h = 0;
                m_v++;
                if (m_v == V_TOTAL) begin
                    m_v = 0;
                    m_frame++;
                end
            end
            en_seen = 1'b1; rst_seen = 1'b0;
        end else begin
            en_seen = 1'b0; rst_seen = 1'b0;
        end
        exp_q.push_back(last_exp);
    end

    // ---------------- monitor ----------------
    int hw = 0, vw = 0, fs_cnt = 0;
    bit fs_have = 1'b0;

    always @(negedge pixelClk) begin
        logic [40:0] act, e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {vid.hClk, vid.vClk, vid.de, vid.frameStart, vid.xCor, vid.yCor,
                   vid.addr, vid.VGA_R, vid.VGA_G, vid.VGA_B};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL scoreboard at %0t: got hs/vs/de/fs=%b x=%0d y=%0d addr=%0d rgb=%h, expected hs/vs/de/fs=%b x=%0d y=%0d addr=%0d rgb=%h",
                         $time, act[40:37], act[36:30], act[29:24], act[23:12], act[11:0],
                         e[40:37], e[36:30], e[29:24], e[23:12], e[11:0]);
            end
        end
        if (rst_seen) begin
            hw = 0; vw = 0; fs_cnt = 0; fs_have = 1'b0;
        end else if (en_seen) begin
            if (vid.hClk == HS_POL) hw++;
            else begin
                if (hw != 0) check("hsync_width", hw, HSW);
                hw = 0;
            end
            if (vid.vClk == VS_POL) vw++;
            else begin
                if (vw != 0) check("vsync_width", vw, VSW * H_TOTAL);
                vw = 0;
            end
            fs_cnt++;
            if (vid.frameStart) begin
                if (fs_have) check("frame_period", fs_cnt, FRAME);
                fs_cnt = 0;
                fs_have = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n, input int en_mode, input bit chg);
        for (int i = 0; i < n; i++) begin
            @(negedge pixelClk);
            case (en_mode)
                0:       pixEn = 1'b1;
                1:       pixEn = ~pixEn;
                default: pixEn = ($urandom_range(0, 3) != 0);
            endcase
            if (chg && $urandom_range(0, 299) == 0) begin
                mode     = 2'($urandom_range(0, 3));
                solidRGB = 12'($urandom);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        pixEn    = 1'b1;
        mode     = 2'd3;
        solidRGB = 12'hF0A;
        repeat (3) @(negedge pixelClk);
        reset_n = 1'b1;
        run(FRAME + 20, 0, 1'b0);
        mode = 2'd0;
        run(FRAME, 0, 1'b0);
        run(FRAME / 2, 0, 1'b0);
        mode = 2'd1;
        run(FRAME, 0, 1'b0);
        mode = 2'd2;
        run(2 * FRAME, 0, 1'b0);
        run(2 * FRAME, 1, 1'b1);
        run(FRAME, 2, 1'b1);
        run($urandom_range(500, 3000), 0, 1'b1);
        @(negedge pixelClk);
        reset_n = 1'b0;
        pixEn   = 1'b0;
        @(negedge pixelClk);
        pixEn   = 1'b1;
        @(negedge pixelClk);
        reset_n = 1'b1;
        run(FRAME + 50, 0, 1'b1);
        repeat (2) @(negedge pixelClk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_pattern.md
# vga_timing_pattern

Parametrised successor to the fixed 640x480 timing-plus-rainbow path. It generates programmable VGA horizontal and vertical timing with selectable sync polarity, a linear framebuffer address, and a run-time-selectable test pattern. All outputs are registered and cycle-aligned. It runs in the pixel-clock domain, downstream of the clock generator, and drives the VGA pins directly.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of hClk (0 = active-low)
- VS_POL, 0, active level of vClk
- CW, 4, bits per colour channel
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE

Ports:
- pixelClk  in  1  pixel clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- pixEn  in  1  pixel enable; counters and all outputs advance only when high
- mode  in  2  pattern select: 0 colour bars, 1 checkerboard, 2 gradient, 3 solid
- solidRGB  in  3*CW  colour for mode 3, packed {R,G,B}
- hClk  out  1  horizontal sync
- vClk  out  1  vertical sync
- de  out  1  high during visible pixels
- xCor  out  $clog2(H_TOTAL)  horizontal counter
- yCor  out  $clog2(V_TOTAL)  vertical counter
- addr  out  ADDR_W  linear pixel address
- frameStart  out  1  one-cycle pulse at pixel (0,0)
- VGA_R / VGA_G / VGA_B  out  CW each  colour outputs

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- Line order: active, front porch, sync, back porch. Frame order is the same, counted in lines.
- hCnt runs 0..H_TOTAL-1 and wraps. vCnt increments when hCnt wraps, runs 0..V_TOTAL-1, and wraps.
- Sync active: hClk = HS_POL when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC. Otherwise hClk = ~HS_POL. vClk follows the same rule on vCnt.
- de = (hCnt < H_ACTIVE) && (vCnt < V_ACTIVE).
- addr is an incremental counter, with no multiplier:
  - cleared at (0,0);
  - incremented after each visible pixel;
  - holds through blanking;
  - so addr = yCor*H_ACTIVE + xCor whenever de=1.
- Mode handling:
  - mode and solidRGB are sampled into shadow registers only at hCnt=0, vCnt=0 (frame boundary);
  - mid-frame changes are ignored until the next frame.
- frameCnt (8 bits) increments at each frame boundary and wraps 255 -> 0.
- Patterns (output is 0 whenever de=0):
  - mode 0: 8 equal vertical bars. Bar k covers x in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8) using integer constants. Order is white, yellow, cyan, green, magenta, red, blue, black. Channel full-scale is all-ones.
  - mode 1: checkerboard with 32-pixel squares. White when x[5]^y[5]=0, black otherwise.
  - mode 2: R = x[CW+4:5], G = y[CW+4:5], B = frameCnt[CW-1:0].
  - mode 3: {R,G,B} = shadow solidRGB.
- pixEn low: every register holds, including outputs.

## Timing
- Latency: one register stage. All outputs on cycle n+1 reflect counter state (hCnt, vCnt) at cycle n. Syncs, de, xCor/yCor, addr, frameStart and RGB are mutually aligned.
- Reset (reset_n low at a pixelClk edge), values at the next edge:
  - counters 0, addr 0, frameCnt 0;
  - shadow mode 0, shadow solidRGB 0;
  - hClk = ~HS_POL, vClk = ~VS_POL;
  - de 0, frameStart 0, RGB 0, xCor/yCor 0.
- Reset mid-line or mid-frame aborts immediately, with no partial-line completion.
- First enabled cycle after reset release:
  - counters at (0,0); mode is sampled then;
  - the following cycle presents pixel (0,0) with de=1 and frameStart=1.
- Wrap at (H_TOTAL-1, V_TOTAL-1): next state is (0,0), frameStart pulses, addr returns to 0.
- Default 640x480 timing:
  - line = 800 clocks, frame = 525 lines;
  - hClk active on hCnt 656..751;
  - vClk active on vCnt 490..491.

## Structure
- Package vga_pkg holds:
  - pattern mode enum (BARS, CHECKER, GRADIENT, SOLID);
  - the 8-entry bar colour constant table;
  - a timing struct type carrying the eight timing fields.
- One sub-module, vga_sync_counter: hCnt/vCnt counters, porch/sync decode and pixEn handling. It outputs raw (unregistered) sync/de/frame-boundary signals.
- The top level holds the address counter, mode shadowing, pattern mux and output register stage.

## Test plan
- Default params, pixEn=1, after reset:
  - 800 clocks between hClk falling edges;
  - hClk low for exactly 96 clocks;
  - vClk low for exactly 1600 clocks (2 lines);
  - frameStart period = 420000 clocks.
- Mode 3, solidRGB=12'hF0A:
  - every de=1 cycle outputs R=F, G=0, B=A;
  - every de=0 cycle outputs 0.
- Mid-frame mode change: drive mode 0 -> 1 at yCor=100. Outputs remain colour bars until frameStart, then pixel (0,0) is white and pixel (32,0) is black.
- addr checks: 0 at (0,0); 639 at (639,0); 640 at (0,1); 307199 at (639,479); back to 0 on the next frameStart.
- Small params H=8/1/2/1, V=4/1/1/1, HS_POL=VS_POL=1:
  - line = 12 clocks, hClk high for 2 clocks at hCnt 9..10;
  - frame = 7 lines;
  - pixEn toggled 1/0 doubles every period and holds outputs constant while low.
- Reset asserted at hCnt=300, vCnt=200:
  - next edge all outputs take their reset values;
  - after release, frameStart occurs 2 enabled cycles later with addr=0.
